// File: rtl/inormalize_pkg.sv
// Shared definitions for the iterative normalizer: step-mode encodings and FSM states.
// Step modes are common with the iterative shifter.
package inormalize_pkg;

  typedef logic [1:0] step_t;

  localparam step_t STEP_CHUNK  = 2'd0;
  localparam step_t STEP_SINGLE = 2'd1;
  localparam step_t STEP_TERM   = 2'd2;

  localparam int CHUNK_SH = 6;
  localparam int CNT_W    = 7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/inormalize_if.sv
// Request/result bundle for the iterative normalizer.
interface inormalize_if #(
  parameter int WIDTH = 32
);
  logic             go;
  logic             sgn;
  logic [WIDTH-1:0] a;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] y;
  logic [6:0]       cnt;
  logic             zero;

  modport master (
    output go, sgn, a,
    input  busy, done, y, cnt, zero
  );

  modport slave (
    input  go, sgn, a,
    output busy, done, y, cnt, zero
  );
endinterface

// File: rtl/inormalize.sv
// Iterative normalizer: shifts the operand left by 6 or 1 per cycle until the
// leading zeros (unsigned) or redundant sign bits (signed) are removed.
module inormalize
  import inormalize_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         arstn,
  inormalize_if.slave  bus
);

  state_t             state_q;
  logic [WIDTH-1:0]   y_q, y_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sgn_q;
  logic               zero_q;
  logic               done_q;
  step_t              step;
  logic               chunk_ok;
  logic               single_ok;

  // Step decision from the current value; a zero operand never shifts.
  always_comb begin
    chunk_ok  = 1'b0;
    single_ok = 1'b0;
    step      = STEP_TERM;
    y_d       = y_q;
    cnt_d     = cnt_q;

    if (sgn_q) begin
      chunk_ok  = (y_q[WIDTH-1:WIDTH-7] == {7{y_q[WIDTH-1]}});
      single_ok = (y_q[WIDTH-1] == y_q[WIDTH-2]);
    end else begin
      chunk_ok  = (y_q[WIDTH-1:WIDTH-6] == 6'd0);
      single_ok = ~y_q[WIDTH-1];
    end

    if (zero_q)         step = STEP_TERM;
    else if (chunk_ok)  step = STEP_CHUNK;
    else if (single_ok) step = STEP_SINGLE;
    else                step = STEP_TERM;

    case (step)
      STEP_CHUNK: begin
        y_d   = y_q << CHUNK_SH;
        cnt_d = cnt_q + CNT_W'(CHUNK_SH);
      end
      STEP_SINGLE: begin
        y_d   = y_q << 1;
        cnt_d = cnt_q + CNT_W'(1);
      end
      default: begin
        y_d   = y_q;
        cnt_d = cnt_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q <= ST_IDLE;
      y_q     <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.go) begin
            state_q <= ST_RUN;
            y_q     <= bus.a;
            sgn_q   <= bus.sgn;
            if (bus.a == '0) begin
              zero_q <= 1'b1;
              cnt_q  <= bus.sgn ? CNT_W'(WIDTH - 1) : CNT_W'(WIDTH);
            end else begin
              zero_q <= 1'b0;
              cnt_q  <= '0;
            end
          end
        end
        ST_RUN: begin
          if (step == STEP_TERM) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end else begin
            y_q   <= y_d;
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy = (state_q == ST_RUN);
  assign bus.done = done_q;
  assign bus.y    = y_q;
  assign bus.cnt  = cnt_q;
  assign bus.zero = zero_q;

endmodule
